// File: rtl/serial_logic_proc.sv
// ---------------------------------------------------------------------------
// serial_logic_proc
//
// Bit-serial logic unit operating on two WIDTH-bit registers A and B. An
// operation shifts both registers right WIDTH times. Each shift computes
// f = F(A[0], B[0]) and refills the vacated MSBs according to the routing
// select R. After WIDTH shifts, A and B hold the bitwise-parallel result.
//
// Optional feature: define SERIAL_LOGIC_OPCOUNT_EN to add an 8-bit count of
// completed operations (OpCount). The count wraps from 255 to 0.
//
// Ports
//   Clk      : clock; all state changes on its rising edge
//   Reset    : synchronous, active-high reset
//   LoadA    : in IDLE, load Din into A
//   LoadB    : in IDLE, load Din into B
//   Execute  : start one operation; hold high and it still runs only once
//   Din      : parallel load data [WIDTH-1:0]
//   F        : function (AND, OR, XOR, ones, NAND, NOR, XNOR, zeros)
//   R        : routing (00 A->A,B->B; 01 A->A,f->B; 10 f->A,B->B; 11 swap)
//   Aval     : register A contents
//   Bval     : register B contents
//   Busy     : high while shifting
//   Done     : one-cycle pulse after the final shift
//   OpCount  : completed operations, 8 bits (only with SERIAL_LOGIC_OPCOUNT_EN)
// ---------------------------------------------------------------------------
module serial_logic_proc #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Execute,
  input  logic [WIDTH-1:0] Din,
  input  logic [2:0]       F,
  input  logic [1:0]       R,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Busy,
`ifdef SERIAL_LOGIC_OPCOUNT_EN
  output logic             Done,
  output logic [7:0]       OpCount
`else
  output logic             Done
`endif
);

  // The counter must be able to hold the value WIDTH, so it never wraps
  // during an operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             f_bit;
  logic             a_msb;
  logic             b_msb;

  function automatic logic logic_fn(input logic [2:0] fsel, input logic a, input logic b);
    case (fsel)
      3'b000:  logic_fn = a & b;
      3'b001:  logic_fn = a | b;
      3'b010:  logic_fn = a ^ b;
      3'b011:  logic_fn = 1'b1;
      3'b100:  logic_fn = ~(a & b);
      3'b101:  logic_fn = ~(a | b);
      3'b110:  logic_fn = ~(a ^ b);
      default: logic_fn = 1'b0;
    endcase
  endfunction

  // F and R are sampled on every shift. Because of this, changing them in
  // the middle of an operation gives mixed per-bit results and has no other
  // effect.
  always_comb begin
    f_bit = logic_fn(F, a_q[0], b_q[0]);
    a_msb = a_q[0];
    b_msb = b_q[0];
    case (R)
      2'b00: begin a_msb = a_q[0]; b_msb = b_q[0]; end
      2'b01: begin a_msb = a_q[0]; b_msb = f_bit;  end
      2'b10: begin a_msb = f_bit;  b_msb = b_q[0]; end
      default: begin a_msb = b_q[0]; b_msb = a_q[0]; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A load blocks Execute. A pending Execute then starts on the first
        // edge where no load is asserted.
        if (LoadA || LoadB) begin
          if (LoadA) a_d = Din;
          if (LoadB) b_d = Din;
        end else if (Execute) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        a_d   = {a_msb, a_q[WIDTH-1:1]};
        b_d   = {b_msb, b_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SHIFT) begin
          state_d = S_HOLD;
          done_d  = 1'b1;
        end
      end
      S_HOLD: begin
        // Hold here until Execute drops, so that a held Execute runs
        // exactly one operation.
        if (!Execute) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign Busy = (state_q == S_SHIFT);
  assign Done = done_q;

`ifdef SERIAL_LOGIC_OPCOUNT_EN
  logic [7:0] opcnt_q, opcnt_d;

  // Update on the same edge that raises Done, so OpCount and Done change
  // together.
  always_comb begin
    opcnt_d = opcnt_q;
    if (done_d) opcnt_d = opcnt_q + 8'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) opcnt_q <= '0;
    else       opcnt_q <= opcnt_d;
  end

  assign OpCount = opcnt_q;
`endif

endmodule
